data_mem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core's MEM stage. It accepts the core's address, write data and write strobe, and returns `read_data` in the same cycle so the MEM/WB register can capture it. It also decodes a small memory-mapped I/O window: a free-running cycle counter, a console TX FIFO with a drain port, a status register and a drop counter. It is instantiated beside the datapath in the top level.

---
 rtl/data_mem_responder.sv | 105 ++++++++++
 tb/tb_data_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data memory for the pipelined MIPS core: word RAM plus a small MMIO window
// (cycle counter, console TX FIFO with drain port, status, drop counter).
module data_mem_responder #(
    parameter int MEM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i32,
    input  logic [31:0] write_data_i32,
    input  logic        enable_wmem_i,
    output logic [31:0] read_data_o32,
    output logic [7:0]  con_data_o8,
    output logic        con_valid_o,
    input  logic        con_ready_i
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_CYCLE   = 2'd0,
        REG_CONSOLE = 2'd1,
        REG_STATUS  = 2'd2,
        REG_DROPS   = 2'd3
    } mmio_reg_e;

    logic [31:0]   mem [MEM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   cycle_cnt, drops;

    logic          is_mmio, store_ok, full, empty, pop, push_req, push_ok, drop;
    mmio_reg_e     reg_sel;
    logic [AW-1:0] ram_idx;
    logic [31:0]   status;
    logic          unused;

    assign is_mmio  = addr_i32[31];
    assign reg_sel  = mmio_reg_e'(addr_i32[3:2]);
    assign ram_idx  = addr_i32[AW+1:2];
    assign unused   = &{1'b0, addr_i32[30:AW+2], addr_i32[1:0]};

    // Stores presented while reset is high must not touch RAM or MMIO.
    assign store_ok = enable_wmem_i && !reset_i;
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && con_ready_i;
    assign push_req = store_ok && is_mmio && (reg_sel == REG_CONSOLE);
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && !push_ok;

    assign con_valid_o = !empty;
    assign con_data_o8 = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign status      = {16'h0000, 8'(count), 6'b000000, empty, full};

    always_comb begin
        read_data_o32 = 32'h0;
        if (!is_mmio) begin
            read_data_o32 = mem[ram_idx];
        end else begin
            case (reg_sel)
                REG_CYCLE:   read_data_o32 = cycle_cnt;
                REG_CONSOLE: read_data_o32 = 32'h0;
                REG_STATUS:  read_data_o32 = status;
                REG_DROPS:   read_data_o32 = drops;
                default:     read_data_o32 = 32'h0;
            endcase
        end
    end

    // RAM and FIFO storage carry no reset; only the bookkeeping state does.
    always_ff @(posedge clk_i) begin
        if (store_ok && !is_mmio)
            mem[ram_idx] <= write_data_i32;
        if (push_ok)
            fifo_mem[wr_ptr] <= write_data_i32[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_cnt <= 32'h0;
            drops     <= 32'h0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (store_ok && is_mmio && (reg_sel == REG_DROPS))
                drops <= 32'h0;
            else if (drop && (drops != 32'hFFFF_FFFF))
                drops <= drops + 32'd1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Push and pop together leave occupancy unchanged.
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, then random traffic vs a queue-based model.
module tb_data_mem_responder;
    localparam int MW = 64;
    localparam int FD = 8;
    localparam int AW = $clog2(MW);
    localparam logic [31:0] A_CYC = 32'h8000_0000;
    localparam logic [31:0] A_CON = 32'h8000_0004;
    localparam logic [31:0] A_ST  = 32'h8000_0008;
    localparam logic [31:0] A_DR  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset_i, enable_wmem_i, con_ready_i, con_valid_o;
    logic [31:0] addr_i32, write_data_i32, read_data_o32;
    logic [7:0]  con_data_o8;

    always #5 clk = ~clk;

    data_mem_responder #(.MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .reset_i(reset_i), .addr_i32(addr_i32),
        .write_data_i32(write_data_i32), .enable_wmem_i(enable_wmem_i),
        .read_data_o32(read_data_o32), .con_data_o8(con_data_o8),
        .con_valid_o(con_valid_o), .con_ready_i(con_ready_i)
    );

    typedef struct {
        bit          rst;
        logic [31:0] a, wd;
        bit          we, rdy;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          chk_con;
        logic [8:0]  exp_con;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    // Reference model: plain arrays, a byte queue and counters.
    logic [31:0] ref_mem [MW];
    bit          ref_known [MW];
    logic [7:0]  ref_q[$];
    logic [31:0] ref_cyc, ref_drops;

    function automatic vec_t mk(bit rst, logic [31:0] a, logic [31:0] wd, bit we, bit rdy,
                                bit chk_rd, logic [31:0] exp_rd, bit chk_con, logic [8:0] exp_con);
        vec_t v;
        v.rst = rst; v.a = a; v.wd = wd; v.we = we; v.rdy = rdy;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.chk_con = chk_con; v.exp_con = exp_con;
        return v;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        int n;
        n = ref_q.size();
        if (!a[31]) return ref_mem[a[AW+1:2]];
        case (a[3:2])
            2'd0:    return ref_cyc;
            2'd1:    return 32'h0;
            2'd2:    return {16'h0, 8'(n), 6'h0, n == 0, n == FD};
            default: return ref_drops;
        endcase
    endfunction

    function automatic logic [8:0] ref_con();
        if (ref_q.size() == 0) return 9'h000;
        return {1'b1, ref_q[0]};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic ref_step(vec_t v);
        bit pop;
        if (v.rst) begin
            ref_cyc = 0;
            ref_drops = 0;
            ref_q.delete();
        end else begin
            pop = (ref_q.size() > 0) && v.rdy;
            if (v.we && !v.a[31]) begin
                ref_mem[v.a[AW+1:2]] = v.wd;
                ref_known[v.a[AW+1:2]] = 1'b1;
            end
            if (pop) void'(ref_q.pop_front());
            if (v.we && v.a[31] && v.a[3:2] == 2'd1) begin
                if (ref_q.size() < FD) ref_q.push_back(v.wd[7:0]);
                else if (ref_drops != 32'hFFFF_FFFF) ref_drops++;
            end
            if (v.we && v.a[31] && v.a[3:2] == 2'd3) ref_drops = 0;
            ref_cyc++;
        end
    endtask

    // Inputs change 1 after the edge, outputs sampled 2 after the edge.
    task automatic do_cycle(vec_t v);
        reset_i = v.rst; addr_i32 = v.a; write_data_i32 = v.wd;
        enable_wmem_i = v.we; con_ready_i = v.rdy;
        #1;
        if (v.chk_rd)  check("table_read", read_data_o32, v.exp_rd);
        if (v.chk_con) check("table_con", {23'h0, con_valid_o, con_data_o8}, {23'h0, v.exp_con});
        if (v.a[31] || ref_known[v.a[AW+1:2]])
            check("model_read", read_data_o32, ref_read(v.a));
        check("model_con", {23'h0, con_valid_o, con_data_o8}, {23'h0, ref_con()});
        @(posedge clk);
        ref_step(v);
        #1;
    endtask

    initial begin
        logic [7:0] drain [8];
        drain = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h6A};
        for (int i = 0; i < MW; i++) ref_known[i] = 1'b0;
        ref_cyc = 0; ref_drops = 0;

        reset_i = 1'b1; addr_i32 = 0; write_data_i32 = 0; enable_wmem_i = 0; con_ready_i = 0;
        repeat (2) @(posedge clk);
        #1;

        vecs.push_back(mk(1, A_ST, 0, 0, 0, 1, 32'h2, 1, 9'h000));
        vecs.push_back(mk(0, A_CYC, 0, 0, 0, 1, 32'd0, 0, 0));
        vecs.push_back(mk(0, A_CYC, 32'h55, 1, 0, 1, 32'd1, 0, 0));
        vecs.push_back(mk(0, A_CYC, 0, 0, 0, 1, 32'd2, 0, 0));
        vecs.push_back(mk(0, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 32'h110, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 32'h10, 32'h11111111, 1, 0, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 32'h13, 0, 0, 0, 1, 32'h11111111, 0, 0));
        vecs.push_back(mk(0, 32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h11111111, 0, 0));
        vecs.push_back(mk(0, A_CYC, 0, 0, 0, 1, 32'd9, 0, 0));
        vecs.push_back(mk(0, A_CON, 32'h41, 1, 0, 1, 32'h0, 1, 9'h000));
        vecs.push_back(mk(0, A_CON, 32'h42, 1, 0, 1, 32'h0, 1, 9'h141));
        vecs.push_back(mk(0, A_CON, 32'h43, 1, 0, 0, 0, 1, 9'h141));
        vecs.push_back(mk(0, 32'h8123_4568, 0, 0, 0, 1, 32'h300, 1, 9'h141));
        vecs.push_back(mk(0, A_ST, 0, 0, 1, 1, 32'h300, 1, 9'h141));
        vecs.push_back(mk(0, A_ST, 0, 0, 1, 1, 32'h200, 1, 9'h142));
        vecs.push_back(mk(0, A_ST, 0, 0, 1, 1, 32'h100, 1, 9'h143));
        vecs.push_back(mk(0, A_ST, 0, 0, 1, 1, 32'h2, 1, 9'h000));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, A_CON, 32'h60 + i, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, A_ST, 0, 0, 0, 1, 32'h801, 1, 9'h160));
        vecs.push_back(mk(0, A_DR, 0, 0, 0, 1, 32'd2, 0, 0));
        vecs.push_back(mk(0, A_CON, 32'h6A, 1, 1, 1, 32'h0, 1, 9'h160));
        vecs.push_back(mk(0, A_DR, 0, 0, 0, 1, 32'd2, 1, 9'h161));
        vecs.push_back(mk(0, A_DR, 0, 1, 0, 1, 32'd2, 1, 9'h161));
        vecs.push_back(mk(0, A_DR, 0, 0, 0, 1, 32'd0, 1, 9'h161));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, A_ST, 0, 0, 1, 0, 0, 1, {1'b1, drain[i]}));
        vecs.push_back(mk(0, A_ST, 0, 0, 0, 1, 32'h2, 1, 9'h000));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, A_CON, 32'h70 + i, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, A_ST, 0, 0, 1, 1, 32'h500, 1, 9'h170));
        vecs.push_back(mk(1, 32'h10, 32'h0BADF00D, 1, 1, 1, 32'hDEADBEEF, 1, 9'h171));
        vecs.push_back(mk(0, A_ST, 0, 0, 1, 1, 32'h2, 1, 9'h000));
        vecs.push_back(mk(0, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, A_CYC, 0, 0, 0, 1, 32'd2, 0, 0));

        foreach (vecs[i]) do_cycle(vecs[i]);

        // Random traffic: skew toward MMIO console pushes so full/drop paths get exercised.
        for (int i = 0; i < 2000; i++) begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst = ($urandom_range(0, 99) == 0);
            v.a   = $urandom();
            if ($urandom_range(0, 2) == 0) v.a[3:2] = 2'd1;
            v.wd  = $urandom();
            v.we  = $urandom_range(0, 1);
            v.rdy = ($urandom_range(0, 3) == 0);
            do_cycle(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
